// File: rtl/des_pkg.sv
// Shared types and helpers for the deserializer lane arbiter.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 8;

    // The round-robin search is written for a fixed maximum channel count so it
    // can live in the package; callers zero-extend their request vector.
    localparam int RR_MAX_CH = 32;
    localparam int RR_IDX_W  = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requesting channel in the order last+1, last+2, ... modulo n_ch.
    // The loop walks the search order backwards so the nearest hit overwrites.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                         input logic [RR_IDX_W-1:0]  last,
                                         input int                   n_ch);
        rr_pick_t            pick;
        logic [RR_IDX_W-1:0] cand;
        pick = '0;
        for (int i = RR_MAX_CH; i >= 1; i--) begin
            if (i <= n_ch) begin
                cand = RR_IDX_W'((int'(last) + i) % n_ch);
                if (req[cand]) begin
                    pick.found = 1'b1;
                    pick.idx   = cand;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/des_lane_arbiter_if.sv
// Requester, grant and word-output bundle of the deserializer lane arbiter.
interface des_lane_arbiter_if
    import des_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = DATA_W_DEFAULT
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   ch_req;
    logic [N_CH-1:0]   ch_serial;
    logic [N_CH-1:0]   ch_gnt;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport slave (
        input  ch_req, ch_serial, out_ready,
        output ch_gnt, out_data, out_ch, out_valid, busy
    );

    modport master (
        output ch_req, ch_serial, out_ready,
        input  ch_gnt, out_data, out_ch, out_valid, busy
    );
endinterface

// File: rtl/des_shift_core.sv
// Serial capture register with its bit counter; bit 0 lands first (LSB first).
module des_shift_core
    import des_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word,
    output logic              last_bit
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0] cnt;

    // Counter is cleared on entry to a transfer and otherwise steps once per sampled bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (sample_en) begin
            word[cnt] <= bit_in;
            cnt       <= cnt + 1'b1;
        end
    end

    assign last_bit = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/des_lane_arbiter.sv
// Round-robin owner of a single serial-to-parallel lane shared by N_CH requesters.
module des_lane_arbiter
    import des_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic               clk,
    input  logic               reset_n,
    des_lane_arbiter_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);

    state_t            state;
    state_t            state_nx;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   last_ptr;
    logic [N_CH-1:0]   gnt_nx;
    logic              valid_nx;
    logic              grant_en;
    logic              capture_en;
    logic              sample_en;
    logic              core_clear;
    logic              bit_in;
    logic              last_bit;
    logic [DATA_W-1:0] core_word;
    rr_pick_t          pick;

    // Next requester after the last served one.
    always_comb pick = rr_pick(RR_MAX_CH'(bus.ch_req), RR_IDX_W'(last_ptr), N_CH);

    // Only the granted channel's serial bit reaches the datapath.
    assign bit_in = bus.ch_serial[sel];

    des_shift_core #(.DATA_W(DATA_W)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (core_clear),
        .sample_en (sample_en),
        .bit_in    (bit_in),
        .word      (core_word),
        .last_bit  (last_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nx   = state;
        gnt_nx     = bus.ch_gnt;
        valid_nx   = bus.out_valid;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        sample_en  = 1'b0;
        core_clear = 1'b0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_nx   = SHIFT;
                    grant_en   = 1'b1;
                    core_clear = 1'b1;
                    gnt_nx     = N_CH'(1) << pick.idx;
                end
            end
            SHIFT: begin
                sample_en = 1'b1;
                if (last_bit) begin
                    capture_en = 1'b1;
                    gnt_nx     = '0;
                    valid_nx   = 1'b1;
                    state_nx   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_valid && bus.out_ready) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    // Output, selection and pointer registers; the final bit bypasses the core
    // so the word is complete on the same edge it is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.ch_gnt    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.busy      <= 1'b0;
            sel           <= '0;
            last_ptr      <= CH_W'(N_CH - 1);
        end else begin
            bus.ch_gnt    <= gnt_nx;
            bus.out_valid <= valid_nx;
            bus.busy      <= (state_nx != IDLE);
            if (grant_en) begin
                sel <= CH_W'(pick.idx);
            end
            if (capture_en) begin
                bus.out_data <= {bit_in, core_word[DATA_W-2:0]};
                bus.out_ch   <= sel;
                last_ptr     <= sel;
            end
        end
    end

endmodule

// File: tb/tb_des_lane_arbiter.sv
// Scoreboard bench for des_lane_arbiter: expected words are queued as stimulus
// is applied and popped when the lane presents a word.
module tb_des_lane_arbiter;
    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct packed {
        logic [N_CH-1:0] gnt;
        logic [7:0]      len;
    } gnt_rec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    des_lane_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    des_lane_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    word_t    sb[$];
    word_t    exp_w;
    gnt_rec_t gnt_log[$];

    logic [DATA_W-1:0] tx [N_CH];
    logic [2:0]        tb_idx [N_CH];
    logic [N_CH-1:0]   noise;
    logic [N_CH-1:0]   run_gnt;
    logic [7:0]        run_len;

    always @(posedge clk) cyc <= cyc + 1;

    // Each requester shifts its word out LSB first while granted.
    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (bus.ch_gnt[c]) tb_idx[c] <= tb_idx[c] + 3'd1;
            else               tb_idx[c] <= 3'd0;
        end
    end

    always @(negedge clk) noise <= N_CH'($urandom);

    // Non-granted channels drive noise on their serial lines.
    always_comb begin
        bus.ch_serial = '0;
        for (int c = 0; c < N_CH; c++) begin
            bus.ch_serial[c] = bus.ch_gnt[c] ? tx[c][tb_idx[c]] : noise[c];
        end
    end

    // Record each grant run as (one-hot grant, length in cycles).
    initial begin
        run_len = 8'd0;
        run_gnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            tx[c]     = '0;
            tb_idx[c] = '0;
        end
    end
    always @(posedge clk) begin
        if (bus.ch_gnt != '0) begin
            run_len <= run_len + 8'd1;
            run_gnt <= bus.ch_gnt;
        end else begin
            if (run_len != 8'd0) gnt_log.push_back('{gnt: run_gnt, len: run_len});
            run_len <= 8'd0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        reset_n       = 1'b0;
        bus.ch_req    = '0;
        bus.out_ready = 1'b0;
        tick(2);
        n_vec++; if (bus.ch_gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt got %b want 0000", bus.ch_gnt); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", bus.out_data); end
        n_vec++; if (bus.out_ch !== 2'd0) begin n_err++; $display("FAIL rst_ch got %0d want 0", bus.out_ch); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        reset_n = 1'b1;
        tick(2);
        n_vec++; if ({bus.busy, bus.ch_gnt} !== 5'b0) begin n_err++; $display("FAIL idle_no_req got busy=%b gnt=%b want 0/0000", bus.busy, bus.ch_gnt); end
    endtask

    task automatic test_single;
        tx[0] = 8'hA5;
        sb.push_back('{ch: 2'd0, data: 8'hA5});
        bus.ch_req = 4'b0001;
        tick(1);
        bus.ch_req = 4'b0000;
        for (int k = 1; k <= DATA_W; k++) begin
            n_vec++; if (bus.ch_gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt_c%0d got %b want 0001", k, bus.ch_gnt); end
            tick(1);
        end
        n_vec++; if (bus.ch_gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_off got %b want 0000", bus.ch_gnt); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_c9 got %b want 1", bus.out_valid); end
        exp_w = sb.pop_front();
        n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL single_word got ch%0d %h want ch%0d %h", bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
        bus.out_ready = 1'b1;
        tick(1);
        n_vec++; if ({bus.out_valid, bus.busy} !== 2'b00) begin n_err++; $display("FAIL single_release got valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rr_pair;
        bit ok;
        gnt_log.delete();
        tx[1] = 8'h3C;
        tx[3] = 8'hC3;
        sb.push_back('{ch: 2'd1, data: 8'h3C});
        sb.push_back('{ch: 2'd3, data: 8'hC3});
        bus.out_ready = 1'b1;
        bus.ch_req    = 4'b1010;
        for (int w = 0; w < 2; w++) begin
            wait_valid(40, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL pair_timeout_w%0d got no out_valid want out_valid", w); end
            if (w == 1) bus.ch_req = 4'b0000;
            exp_w = sb.pop_front();
            n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL pair_word%0d got ch%0d %h want ch%0d %h", w, bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
            tick(1);
        end
        tick(2);
        n_vec++; if (gnt_log.size() != 2) begin n_err++; $display("FAIL pair_runs got %0d want 2", gnt_log.size()); end
        else begin
            n_vec++; if (gnt_log[0] !== '{gnt: 4'b0010, len: 8'd8}) begin n_err++; $display("FAIL pair_run0 got %b/%0d want 0010/8", gnt_log[0].gnt, gnt_log[0].len); end
            n_vec++; if (gnt_log[1] !== '{gnt: 4'b1000, len: 8'd8}) begin n_err++; $display("FAIL pair_run1 got %b/%0d want 1000/8", gnt_log[1].gnt, gnt_log[1].len); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int t_prev;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        gnt_log.delete();
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        for (int w = 0; w < 6; w++) sb.push_back('{ch: CH_W'(order[w]), data: tx[order[w]]});
        bus.out_ready = 1'b1;
        bus.ch_req    = 4'b1111;
        t_prev = 0;
        for (int w = 0; w < 6; w++) begin
            wait_valid(40, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout_w%0d got no out_valid want out_valid", w); end
            if (w == 5) bus.ch_req = 4'b0000;
            exp_w = sb.pop_front();
            n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL b2b_word%0d got ch%0d %h want ch%0d %h", w, bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
            if (w > 0) begin
                n_vec++; if (cyc - t_prev != 10) begin n_err++; $display("FAIL b2b_gap%0d got %0d want 10", w, cyc - t_prev); end
            end
            t_prev = cyc;
            tick(1);
        end
        tick(2);
        n_vec++; if (gnt_log.size() != 6) begin n_err++; $display("FAIL b2b_runs got %0d want 6", gnt_log.size()); end
        else begin
            for (int w = 0; w < 6; w++) begin
                n_vec++; if (gnt_log[w] !== '{gnt: N_CH'(1) << order[w], len: 8'd8}) begin n_err++; $display("FAIL b2b_run%0d got %b/%0d want ch%0d/8", w, gnt_log[w].gnt, gnt_log[w].len, order[w]); end
            end
        end
    endtask

    task automatic test_hold;
        bit ok;
        tx[2] = 8'h5A;
        tx[0] = 8'h96;
        sb.push_back('{ch: 2'd2, data: 8'h5A});
        sb.push_back('{ch: 2'd0, data: 8'h96});
        bus.out_ready = 1'b0;
        bus.ch_req    = 4'b0101;
        wait_valid(40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL hold_timeout got no out_valid want out_valid"); end
        exp_w = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_vec++; if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_err++; $display("FAIL hold_word_c%0d got v%b ch%0d %h want v1 ch%0d %h", k, bus.out_valid, bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
            n_vec++; if (bus.ch_gnt !== 4'b0000) begin n_err++; $display("FAIL hold_gnt_c%0d got %b want 0000", k, bus.ch_gnt); end
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(1);
        n_vec++; if ({bus.out_valid, bus.busy, bus.ch_gnt} !== 6'b0) begin n_err++; $display("FAIL hold_idle got v%b busy%b gnt%b want 0/0/0000", bus.out_valid, bus.busy, bus.ch_gnt); end
        tick(1);
        n_vec++; if (bus.ch_gnt !== 4'b0001) begin n_err++; $display("FAIL hold_next_gnt got %b want 0001", bus.ch_gnt); end
        bus.ch_req = 4'b0000;
        wait_valid(40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL hold2_timeout got no out_valid want out_valid"); end
        exp_w = sb.pop_front();
        n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL hold2_word got ch%0d %h want ch%0d %h", bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
        tick(1);
    endtask

    task automatic test_reset_mid;
        bit ok;
        tx[1] = 8'hE7;
        bus.out_ready = 1'b1;
        bus.ch_req    = 4'b0010;
        tick(1);
        n_vec++; if (bus.ch_gnt !== 4'b0010) begin n_err++; $display("FAIL rmid_gnt got %b want 0010", bus.ch_gnt); end
        bus.ch_req = 4'b0000;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        n_vec++; if ({bus.ch_gnt, bus.out_valid, bus.busy} !== 6'b0) begin n_err++; $display("FAIL rmid_cut got gnt%b v%b busy%b want 0000/0/0", bus.ch_gnt, bus.out_valid, bus.busy); end
        reset_n = 1'b1;
        tx[0] = 8'h0F;
        tx[1] = 8'hF0;
        sb.push_back('{ch: 2'd0, data: 8'h0F});
        sb.push_back('{ch: 2'd1, data: 8'hF0});
        bus.ch_req = 4'b0011;
        tick(1);
        n_vec++; if ({bus.ch_gnt, bus.out_valid} !== 5'b00010) begin n_err++; $display("FAIL rmid_first got gnt%b v%b want 0001/0", bus.ch_gnt, bus.out_valid); end
        for (int w = 0; w < 2; w++) begin
            wait_valid(40, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_timeout_w%0d got no out_valid want out_valid", w); end
            if (w == 1) bus.ch_req = 4'b0000;
            exp_w = sb.pop_front();
            n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL rmid_word%0d got ch%0d %h want ch%0d %h", w, bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
            tick(1);
        end
    endtask

    task automatic test_req_drop;
        bit ok;
        gnt_log.delete();
        tx[2] = 8'hB4;
        sb.push_back('{ch: 2'd2, data: 8'hB4});
        bus.out_ready = 1'b1;
        bus.ch_req    = 4'b0100;
        tick(1);
        n_vec++; if (bus.ch_gnt !== 4'b0100) begin n_err++; $display("FAIL drop_gnt got %b want 0100", bus.ch_gnt); end
        tick(2);
        bus.ch_req = 4'b0000;
        wait_valid(40, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL drop_timeout got no out_valid want out_valid"); end
        exp_w = sb.pop_front();
        n_vec++; if ({bus.out_ch, bus.out_data} !== exp_w) begin n_err++; $display("FAIL drop_word got ch%0d %h want ch%0d %h", bus.out_ch, bus.out_data, exp_w.ch, exp_w.data); end
        tick(3);
        n_vec++; if (gnt_log.size() != 1 || gnt_log[0].len !== 8'd8) begin n_err++; $display("FAIL drop_run got %0d runs len %0d want 1 run len 8", gnt_log.size(), (gnt_log.size() != 0) ? gnt_log[0].len : 8'd0); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ch_req    = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_rr_pair();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_req_drop();
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want completion");
        $fatal(1, "bench timeout");
    end

endmodule
